// File: rtl/seq_restoring_divider.sv
// -----------------------------------------------------------------------------
// seq_restoring_divider
//   Unsigned restoring divider. One (WIDTH+1)-bit ripple-borrow subtraction per
//   clock, one quotient bit per iteration, WIDTH iterations per division.
//   A zero divisor skips the iterations and reports div_by_zero at once.
//
// Ports
//   i_clk          rising-edge clock
//   i_rst_n        asynchronous active-low reset
//   i_start        division request, accepted only while idle
//   i_dividend     unsigned dividend, sampled on an accepted start
//   i_divisor      unsigned divisor, sampled on an accepted start
//   o_busy         high while iterating and during the done cycle
//   o_done         one-cycle pulse, results valid from this cycle on
//   o_quotient     registered quotient (all ones on divide-by-zero)
//   o_remainder    registered remainder (dividend on divide-by-zero)
//   o_div_by_zero  registered, set with done when the divisor was zero
// -----------------------------------------------------------------------------
module seq_restoring_divider #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_dividend,
   input  logic [WIDTH-1:0] i_divisor,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_quotient,
   output logic [WIDTH-1:0] o_remainder,
   output logic             o_div_by_zero
);

   localparam int unsigned CntW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_e;

   state_e           r_state;
   logic [WIDTH:0]   r_rem;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_dvs;
   logic [CntW-1:0]  r_cnt;
   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] r_quot;
   logic [WIDTH-1:0] r_remd;
   logic             r_dbz;

   logic [WIDTH:0]   w_shifted;
   logic [WIDTH:0]   w_subtr;
   logic [WIDTH:0]   w_diff;
   logic             w_bchain;
   logic             w_bout;
   logic [WIDTH:0]   w_rem_next;
   logic [WIDTH-1:0] w_q_next;
   logic             w_unused_rem_msb;

   // The partial remainder stays below the divisor, so its MSB never feeds the shift.
   assign w_unused_rem_msb = r_rem[WIDTH];

   assign w_shifted = {r_rem[WIDTH-1:0], r_q[WIDTH-1]};
   assign w_subtr   = {1'b0, r_dvs};

   // Ripple-borrow full-subtractor chain, borrow-in tied low.
   always_comb begin
      w_diff   = '0;
      w_bchain = 1'b0;
      for (int unsigned i = 0; i <= WIDTH; i++) begin
         w_diff[i] = w_shifted[i] ^ w_subtr[i] ^ w_bchain;
         w_bchain  = (~w_shifted[i] & w_subtr[i]) |
                     (~(w_shifted[i] ^ w_subtr[i]) & w_bchain);
      end
      w_bout = w_bchain;
   end

   // Borrow out means the trial subtraction went negative: restore and shift in 0.
   assign w_rem_next = w_bout ? w_shifted : w_diff;
   assign w_q_next   = {r_q[WIDTH-2:0], ~w_bout};

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= StIdle;
         r_rem   <= '0;
         r_q     <= '0;
         r_dvs   <= '0;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_quot  <= '0;
         r_remd  <= '0;
         r_dbz   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            StIdle: begin
               if (i_start) begin
                  r_q    <= i_dividend;
                  r_dvs  <= i_divisor;
                  r_rem  <= '0;
                  r_cnt  <= CntW'(WIDTH);
                  r_busy <= 1'b1;
                  if (i_divisor == '0) begin
                     r_state <= StDone;
                     r_done  <= 1'b1;
                     r_quot  <= '1;
                     r_remd  <= i_dividend;
                     r_dbz   <= 1'b1;
                  end else begin
                     r_state <= StRun;
                  end
               end
            end
            StRun: begin
               r_rem <= w_rem_next;
               r_q   <= w_q_next;
               r_cnt <= r_cnt - 1'b1;
               // Last iteration: results go straight to the output registers.
               if (r_cnt == CntW'(1)) begin
                  r_state <= StDone;
                  r_done  <= 1'b1;
                  r_quot  <= w_q_next;
                  r_remd  <= w_rem_next[WIDTH-1:0];
                  r_dbz   <= 1'b0;
               end
            end
            StDone: begin
               r_state <= StIdle;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= StIdle;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign o_busy        = r_busy;
   assign o_done        = r_done;
   assign o_quotient    = r_quot;
   assign o_remainder   = r_remd;
   assign o_div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_restoring_divider
//   Table-driven directed vectors, hand-written corner sequences (ignored starts,
//   reset mid-run) and a randomized back-to-back run against a plain-arithmetic
//   reference model.
// -----------------------------------------------------------------------------
module tb_seq_restoring_divider;

   localparam int unsigned W = 32;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         busy;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;

   int vec_cnt  = 0;
   int miss_cnt = 0;
   int cyc      = 0;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         z;
      int           lat;
   } vec_t;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
   } pair_t;

   vec_t  tbl[6];
   pair_t pend[$];

   seq_restoring_divider #(.WIDTH(W)) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_start       (start),
      .i_dividend    (dividend),
      .i_divisor     (divisor),
      .o_busy        (busy),
      .o_done        (done),
      .o_quotient    (quotient),
      .o_remainder   (remainder),
      .o_div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         miss_cnt++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Called at a negedge; returns at the negedge where done is seen (or timeout).
   task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat   = 1;
      chk("busy_after_start", 64'(busy), 64'd1);
      while (done !== 1'b1 && lat < 100) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic after_done();
      @(negedge clk);
      chk("done_cleared", 64'(done), 64'd0);
      chk("busy_cleared", 64'(busy), 64'd0);
   endtask

   initial begin
      int           lat;
      int           last_done;
      int           n_done;
      int           wait_cnt;
      bit           saw_done;
      pair_t        p;
      pair_t        e;
      logic [W-1:0] eq;
      logic [W-1:0] er;

      tbl[0] = '{a: 32'd100,        b: 32'd7,          q: 32'd14,         r: 32'd2, z: 1'b0, lat: 33};
      tbl[1] = '{a: 32'hFFFF_FFFF,  b: 32'd1,          q: 32'hFFFF_FFFF,  r: 32'd0, z: 1'b0, lat: 33};
      tbl[2] = '{a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  q: 32'd1,          r: 32'd0, z: 1'b0, lat: 33};
      tbl[3] = '{a: 32'd3,          b: 32'd10,         q: 32'd0,          r: 32'd3, z: 1'b0, lat: 33};
      tbl[4] = '{a: 32'd5,          b: 32'd0,          q: 32'hFFFF_FFFF,  r: 32'd5, z: 1'b1, lat: 1};
      tbl[5] = '{a: 32'd9,          b: 32'd2,          q: 32'd4,          r: 32'd1, z: 1'b0, lat: 33};

      rst_n    = 1'b0;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_quot", 64'(quotient), 64'd0);
      chk("rst_rem",  64'(remainder), 64'd0);
      chk("rst_dbz",  64'(div_by_zero), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed table
      for (int i = 0; i < 6; i++) begin
         run_div(tbl[i].a, tbl[i].b, lat);
         chk($sformatf("tbl%0d_lat", i),  64'(lat), 64'(tbl[i].lat));
         chk($sformatf("tbl%0d_quot", i), 64'(quotient), 64'(tbl[i].q));
         chk($sformatf("tbl%0d_rem", i),  64'(remainder), 64'(tbl[i].r));
         chk($sformatf("tbl%0d_dbz", i),  64'(div_by_zero), 64'(tbl[i].z));
         after_done();
      end

      // Starts during RUN and DONE are ignored; operands change freely after capture
      dividend = 32'd1000;
      divisor  = 32'd3;
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      dividend = 32'd50;
      divisor  = 32'd5;
      lat      = 1;
      while (done !== 1'b1 && lat < 100) begin
         start = (lat == 10);
         @(negedge clk);
         lat++;
      end
      start = 1'b0;
      chk("ign_lat",  64'(lat), 64'd33);
      chk("ign_quot", 64'(quotient), 64'd333);
      chk("ign_rem",  64'(remainder), 64'd1);
      chk("ign_dbz",  64'(div_by_zero), 64'd0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("ign_done_start_busy", 64'(busy), 64'd0);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("hold_busy", 64'(busy), 64'd0);
         chk("hold_done", 64'(done), 64'd0);
         chk("hold_quot", 64'(quotient), 64'd333);
         chk("hold_rem",  64'(remainder), 64'd1);
      end

      // Reset mid-RUN aborts without a done pulse
      dividend = 32'h8000_0000;
      divisor  = 32'd3;
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      saw_done = 1'b0;
      for (int i = 1; i < 16; i++) begin
         if (done === 1'b1) saw_done = 1'b1;
         @(negedge clk);
      end
      chk("abort_busy_before_rst", 64'(busy), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_quot", 64'(quotient), 64'd0);
      chk("abort_rem",  64'(remainder), 64'd0);
      chk("abort_dbz",  64'(div_by_zero), 64'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (done === 1'b1) saw_done = 1'b1;
      end
      chk("abort_no_done", 64'(saw_done), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      run_div(32'd21, 32'd4, lat);
      chk("post_rst_lat",  64'(lat), 64'd33);
      chk("post_rst_quot", 64'(quotient), 64'd5);
      chk("post_rst_rem",  64'(remainder), 64'd1);
      after_done();

      // Random back-to-back with start held high
      p.a = $urandom;
      p.b = $urandom_range(0, 1) ? 32'($urandom_range(1, 1000)) : 32'($urandom);
      if (p.b == '0) p.b = 32'd1;
      pend.push_back(p);
      dividend  = p.a;
      divisor   = p.b;
      start     = 1'b1;
      last_done = -1;
      n_done    = 0;
      wait_cnt  = 0;
      while (n_done < 1000) begin
         @(negedge clk);
         wait_cnt++;
         if (done === 1'b1) begin
            e  = pend.pop_front();
            eq = e.a / e.b;
            er = e.a % e.b;
            chk("rand_quot", 64'(quotient), 64'(eq));
            chk("rand_rem",  64'(remainder), 64'(er));
            chk("rand_rem_lt_dvs", 64'(remainder < e.b), 64'd1);
            chk("rand_invariant",
                64'(quotient) * 64'(e.b) + 64'(remainder), 64'(e.a));
            if (last_done >= 0) chk("rand_spacing", 64'(cyc - last_done), 64'd34);
            last_done = cyc;
            n_done++;
            wait_cnt = 0;
            p.a = $urandom;
            p.b = $urandom_range(0, 1) ? 32'($urandom_range(1, 1000)) : 32'($urandom);
            if (p.b == '0) p.b = 32'd1;
            pend.push_back(p);
            dividend = p.a;
            divisor  = p.b;
         end else if (wait_cnt > 100) begin
            chk("rand_timeout", 64'(done), 64'd1);
            break;
         end
      end
      start = 1'b0;
      repeat (40) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule

// File: doc/seq_restoring_divider.md
Name: seq_restoring_divider

Overview:
- Unsigned restoring divider controller that sequences one (WIDTH+1)-bit ripple-borrow subtractor (the team's full-subtractor chain, b_in tied 0) over WIDTH iterations.
- Produces quotient and remainder of dividend/divisor, one quotient bit per clock.
- Sits beside the subtractor datapath as its only user and handles operand capture, iteration counting, result hold and divide-by-zero.

Parameters:
- WIDTH, 32, operand/quotient/remainder width in bits; legal range 2..64.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; accepted only in IDLE
- dividend  input  WIDTH  unsigned dividend, sampled on accepted start
- divisor  input  WIDTH  unsigned divisor, sampled on accepted start
- busy  output  1  high in RUN and DONE states
- done  output  1  one-cycle pulse; results valid from this cycle
- quotient  output  WIDTH  result quotient
- remainder  output  WIDTH  result remainder
- div_by_zero  output  1  set with done when captured divisor == 0

Behaviour:
- Reset: rst_n low asynchronously forces IDLE and clears all internal registers. Outputs busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
- Registers:
  - rem_r, WIDTH+1 bits, partial remainder.
  - q_r, WIDTH bits; holds the dividend and shifts in quotient bits.
  - dvs_r, WIDTH bits.
  - cnt_r, ceil(log2(WIDTH))+1 bits.
- States: IDLE, RUN, DONE.
- IDLE:
  - busy=0.
  - On start=1, capture dividend into q_r and divisor into dvs_r, clear rem_r, set cnt_r=WIDTH.
  - Next state is DONE if divisor==0, else RUN.
  - With start=0, remain in IDLE.
- RUN, one iteration per cycle:
  - shifted = {rem_r[WIDTH-1:0], q_r[WIDTH-1]}.
  - Subtractor computes shifted - {1'b0, dvs_r} with borrow-in 0, giving diff and b_out.
  - If b_out==0: rem_r <= diff, q_r <= {q_r[WIDTH-2:0], 1'b1}.
  - If b_out==1: rem_r <= shifted, q_r <= {q_r[WIDTH-2:0], 1'b0}.
  - cnt_r decrements each cycle. When cnt_r==1 at the clock edge, the iteration completes and the next state is DONE.
- DONE, exactly one cycle:
  - done=1, busy=1, then IDLE.
  - Normal case: quotient=q_r, remainder=rem_r[WIDTH-1:0], div_by_zero=0.
  - Divide-by-zero case: quotient=all ones, remainder=captured dividend, div_by_zero=1.
- Output registers: quotient, remainder and div_by_zero are registered. They update on entry to DONE and hold until the next DONE entry or reset. done is low in every other cycle.
- Latency:
  - Start accepted at edge E0.
  - Normal division: done high in the cycle after edge E0+WIDTH, i.e. WIDTH+1 cycles after the start cycle.
  - Divisor 0: done in the cycle after E0.
- start while busy=1 (RUN or DONE) is ignored; no queuing, no effect on operands.
- start held high continuously begins a new division in the first IDLE cycle after DONE. Back-to-back issue rate is one division per WIDTH+2 cycles.
- Operand inputs may change freely after the accepted start.
- Reset mid-RUN aborts the operation: IDLE, outputs cleared, no done pulse.
- Arithmetic:
  - The subtraction is always WIDTH+1 bits so that a shifted remainder ≥ 2^WIDTH cannot occur undetected.
  - Remainder < divisor is guaranteed for nonzero divisor.
  - Invariant: dividend == quotient*divisor + remainder.

Test Plan (WIDTH=32):
- Reset, then start with 100/7 → busy rises next cycle; done pulses exactly 33 cycles after the start cycle; quotient=14, remainder=2, div_by_zero=0; busy low the cycle after done.
- 0xFFFFFFFF/1 → quotient=0xFFFFFFFF, remainder=0. Then 0xFFFFFFFF/0xFFFFFFFF → quotient=1, remainder=0. Then 3/10 → quotient=0, remainder=3.
- 5/0 → done 1 cycle after the start cycle; quotient=0xFFFFFFFF, remainder=5, div_by_zero=1. Next division 9/2 → quotient=4, remainder=1, div_by_zero=0.
- Start 1000/3, pulse start with 50/5 during RUN cycle 10 and during the DONE cycle → both ignored; result quotient=333, remainder=1; outputs hold through 20 idle cycles.
- Start 0x80000000/3; assert rst_n=0 mid-RUN at cycle 16 → outputs immediately 0, no done pulse. After release, 21/4 → quotient=5, remainder=1, latency 33.
- Random 1000 operand pairs with start held high → each result satisfies the invariant and remainder<divisor; done spacing is 34 cycles.
